// File: rtl/mor1kx_wb32_slave_ram_if.sv
// Wishbone B3 32-bit bus bundle between a CPU-side master and a RAM slave.
// Ports: adr/dat_i/sel/we/cyc/stb/cti/bte from master; dat_o/ack/err/rty back.
interface mor1kx_wb32_slave_ram_if;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic        wbs_we_i;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic [2:0]  wbs_cti_i;
    logic [1:0]  wbs_bte_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        wbs_err_o;
    logic        wbs_rty_o;

    modport master (
        output wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i,
        output wbs_cyc_i, wbs_stb_i, wbs_cti_i, wbs_bte_i,
        input  wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
    );

    modport slave (
        input  wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i,
        input  wbs_cyc_i, wbs_stb_i, wbs_cti_i, wbs_bte_i,
        output wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
    );
endinterface

// File: rtl/mor1kx_wb32_slave_ram.sv
// Wishbone B3 slave backed by a 2**AW x 32 single-port RAM, classic + bursts.
// Ports: clk, rst_n (async active-low), wb (slave modport of the bus bundle).
module mor1kx_wb32_slave_ram #(
    parameter int          AW          = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    mor1kx_wb32_slave_ram_if.slave       wb
);

    localparam int HB = AW + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SINGLE,
        S_BURST,
        S_ERR
    } state_t;

    logic [31:0]   mem [2**AW];

    state_t        state, state_nxt;
    logic [AW-1:0] addr, addr_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic          burst, burst_nxt;
    logic          ack, ack_nxt;
    logic          err, err_nxt;
    logic [31:0]   dat, dat_nxt;

    logic          req;
    logic          hit;
    logic          cti_inc;
    logic [AW-1:0] adr_word;
    logic [AW-1:0] addr_inc;
    logic [31:0]   wdata;
    logic          wr_en;
    logic          unused;

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] nw,
        input logic [3:0]  sel
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    // Wrap bursts keep the upper bits and only roll the low 2/3/4 bits.
    function automatic logic [AW-1:0] next_addr(
        input logic [AW-1:0] a,
        input logic [1:0]    bte
    );
        logic [AW-1:0] m;
        logic [AW-1:0] inc;
        inc = a + AW'(1);
        case (bte)
            2'b01:   m = AW'(3);
            2'b10:   m = AW'(7);
            2'b11:   m = AW'(15);
            default: m = '1;
        endcase
        return (a & ~m) | (inc & m);
    endfunction

    assign req      = wb.wbs_cyc_i & wb.wbs_stb_i;
    assign hit      = wb.wbs_adr_i[31:HB] == BASE_ADDR[31:HB];
    assign cti_inc  = wb.wbs_cti_i == 3'b010;
    assign adr_word = wb.wbs_adr_i[HB-1:2];
    assign addr_inc = next_addr(addr, wb.wbs_bte_i);
    assign wdata    = merge(mem[addr], wb.wbs_dat_i, wb.wbs_sel_i);
    assign unused   = ^wb.wbs_adr_i[1:0];

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        cnt_nxt   = cnt;
        burst_nxt = burst;
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;
        dat_nxt   = dat;
        wr_en     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req) begin
                    if (!hit) begin
                        state_nxt = S_ERR;
                        err_nxt   = 1'b1;
                    end else begin
                        addr_nxt  = adr_word;
                        burst_nxt = cti_inc;
                        if (WAIT_STATES != 0) begin
                            state_nxt = S_WAIT;
                            cnt_nxt   = 4'(WAIT_STATES - 1);
                        end else begin
                            ack_nxt   = 1'b1;
                            dat_nxt   = mem[adr_word];
                            state_nxt = cti_inc ? S_BURST : S_SINGLE;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_nxt = S_IDLE;
                end else if (cnt == 4'd0) begin
                    ack_nxt   = 1'b1;
                    dat_nxt   = mem[addr];
                    state_nxt = burst ? S_BURST : S_SINGLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_SINGLE: begin
                wr_en     = req & wb.wbs_we_i;
                state_nxt = S_IDLE;
            end
            S_BURST: begin
                if (!req) begin
                    state_nxt = S_IDLE;
                end else begin
                    wr_en = wb.wbs_we_i;
                    if (cti_inc) begin
                        addr_nxt = addr_inc;
                        ack_nxt  = 1'b1;
                        // Prefetch sees this beat's write if it hits the same word.
                        if (wr_en && addr_inc == addr) dat_nxt = wdata;
                        else                           dat_nxt = mem[addr_inc];
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_ERR: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr  <= '0;
            cnt   <= 4'd0;
            burst <= 1'b0;
            ack   <= 1'b0;
            err   <= 1'b0;
            dat   <= 32'h0;
        end else begin
            addr  <= addr_nxt;
            cnt   <= cnt_nxt;
            burst <= burst_nxt;
            ack   <= ack_nxt;
            err   <= err_nxt;
            dat   <= dat_nxt;
        end
    end

    // RAM is deliberately not reset; reset only forces the FSM idle.
    always_ff @(posedge clk) begin
        if (wr_en) mem[addr] <= wdata;
    end

    assign wb.wbs_dat_o = dat;
    assign wb.wbs_ack_o = ack;
    assign wb.wbs_err_o = err;
    assign wb.wbs_rty_o = 1'b0;

endmodule

// File: tb/tb_mor1kx_wb32_slave_ram.sv
// Testbench for mor1kx_wb32_slave_ram: two instances (2 wait states / base 0,
// 0 wait states / base 0x1000_0000) driven by one master, scoreboarded reads.
module tb_mor1kx_wb32_slave_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] m_adr, m_dat;
    logic [3:0]  m_sel;
    logic        m_we, m_cyc, m_stb, use_b;
    logic [2:0]  m_cti;
    logic [1:0]  m_bte;

    mor1kx_wb32_slave_ram_if ia();
    mor1kx_wb32_slave_ram_if ib();

    assign ia.wbs_adr_i = m_adr;
    assign ia.wbs_dat_i = m_dat;
    assign ia.wbs_sel_i = m_sel;
    assign ia.wbs_we_i  = m_we;
    assign ia.wbs_cyc_i = m_cyc & ~use_b;
    assign ia.wbs_stb_i = m_stb;
    assign ia.wbs_cti_i = m_cti;
    assign ia.wbs_bte_i = m_bte;
    assign ib.wbs_adr_i = m_adr;
    assign ib.wbs_dat_i = m_dat;
    assign ib.wbs_sel_i = m_sel;
    assign ib.wbs_we_i  = m_we;
    assign ib.wbs_cyc_i = m_cyc & use_b;
    assign ib.wbs_stb_i = m_stb;
    assign ib.wbs_cti_i = m_cti;
    assign ib.wbs_bte_i = m_bte;

    mor1kx_wb32_slave_ram #(
        .AW(10), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .wb(ia.slave)
    );

    mor1kx_wb32_slave_ram #(
        .AW(10), .BASE_ADDR(32'h1000_0000), .WAIT_STATES(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .wb(ib.slave)
    );

    logic        r_ack, r_err;
    logic [31:0] r_dat;
    assign r_ack = use_b ? ib.wbs_ack_o : ia.wbs_ack_o;
    assign r_err = use_b ? ib.wbs_err_o : ia.wbs_err_o;
    assign r_dat = use_b ? ib.wbs_dat_o : ia.wbs_dat_o;

    logic [31:0] ma [1024];
    logic [31:0] mb [1024];
    logic [31:0] exp_q [$];
    int vectors = 0;
    int miscompares = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s);
        logic [31:0] w;
        w = use_b ? mb[a[11:2]] : ma[a[11:2]];
        for (int i = 0; i < 4; i++)
            if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        if (use_b) mb[a[11:2]] = w;
        else       ma[a[11:2]] = w;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return use_b ? mb[a[11:2]] : ma[a[11:2]];
    endfunction

    task automatic classic(input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] s,
                           output int lat, output logic [31:0] rd,
                           output logic a_seen, output logic e_seen,
                           output logic a_after, output logic e_after);
        m_adr = a; m_we = w; m_dat = d; m_sel = s;
        m_cti = 3'b000; m_bte = 2'b00; m_cyc = 1'b1; m_stb = 1'b1;
        lat = -1; rd = '0; a_seen = 1'b0; e_seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (r_ack || r_err) begin
                lat = i; a_seen = r_ack; e_seen = r_err; rd = r_dat;
                break;
            end
        end
        tick();
        a_after = r_ack; e_after = r_err;
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        int lat;
        logic [31:0] rd;
        logic as, es, aa, ea;
        classic(a, 1'b1, d, s, lat, rd, as, es, aa, ea);
        model_write(a, d, s);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        tick(); tick();
        vectors++;
        if (ia.wbs_ack_o !== 1'b0 || ia.wbs_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_a_flags: got ack=%b err=%b want 0 0", ia.wbs_ack_o, ia.wbs_err_o);
        end
        vectors++;
        if (ia.wbs_dat_o !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_a_dat: got %h want 00000000", ia.wbs_dat_o);
        end
        vectors++;
        if (ib.wbs_ack_o !== 1'b0 || ib.wbs_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_b_flags: got ack=%b err=%b want 0 0", ib.wbs_ack_o, ib.wbs_err_o);
        end
        vectors++;
        if (ib.wbs_dat_o !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_b_dat: got %h want 00000000", ib.wbs_dat_o);
        end
        vectors++;
        if (ia.wbs_rty_o !== 1'b0 || ib.wbs_rty_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_rty: got %b%b want 00", ia.wbs_rty_o, ib.wbs_rty_o);
        end
        @(negedge clk) rst_n = 1'b1;
        tick(); tick();
        vectors++;
        if (ia.wbs_ack_o !== 1'b0 || ib.wbs_ack_o !== 1'b0) begin
            miscompares++;
            $display("FAIL post_rst_idle: got ack %b%b want 00", ia.wbs_ack_o, ib.wbs_ack_o);
        end
    endtask

    task automatic test_classic();
        int lat;
        logic [31:0] rd, ev;
        logic as, es, aa, ea;
        use_b = 1'b0;
        classic(32'h40, 1'b1, 32'hDEADBEEF, 4'hF, lat, rd, as, es, aa, ea);
        model_write(32'h40, 32'hDEADBEEF, 4'hF);
        vectors++;
        if (lat !== 3 || as !== 1'b1) begin
            miscompares++;
            $display("FAIL cl_wr_lat: got %0d ack=%b want 3 1", lat, as);
        end
        wr(32'h44, 32'hAABBCCDD, 4'hF);
        wr(32'h44, 32'h11223344, 4'b0101);
        exp_q.push_back(model_read(32'h40));
        classic(32'h40, 1'b0, 32'h0, 4'hF, lat, rd, as, es, aa, ea);
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("FAIL cl_rd_lat: got %0d want 3", lat);
        end
        vectors++;
        if (aa !== 1'b0) begin
            miscompares++;
            $display("FAIL cl_ack_width: got ack=%b after ack cycle want 0", aa);
        end
        ev = exp_q.pop_front();
        vectors++;
        if (rd !== ev) begin
            miscompares++;
            $display("FAIL cl_rd_data: got %h want %h", rd, ev);
        end
        exp_q.push_back(model_read(32'h44));
        classic(32'h44, 1'b0, 32'h0, 4'hF, lat, rd, as, es, aa, ea);
        ev = exp_q.pop_front();
        vectors++;
        if (rd !== ev || !as) begin
            miscompares++;
            $display("FAIL cl_sel_merge: got %h want %h", rd, ev);
        end
    endtask

    task automatic test_wrap8();
        logic [31:0] ev;
        use_b = 1'b1;
        for (int i = 0; i < 8; i++)
            wr(32'h1000_0000 + 32'(4*i), 32'hC0DE_0000 + 32'(i * 32'h0101), 4'hF);
        for (int j = 0; j < 8; j++)
            exp_q.push_back(mb[(7 + j) % 8]);
        m_adr = 32'h1000_001C; m_we = 1'b0; m_sel = 4'hF;
        m_cti = 3'b010; m_bte = 2'b10; m_cyc = 1'b1; m_stb = 1'b1;
        tick();
        for (int j = 0; j < 8; j++) begin
            if (j == 7) m_cti = 3'b111;
            vectors++;
            if (r_ack !== 1'b1) begin
                miscompares++;
                $display("FAIL wrap8_ack beat %0d: got %b want 1", j, r_ack);
            end
            ev = exp_q.pop_front();
            vectors++;
            if (r_dat !== ev) begin
                miscompares++;
                $display("FAIL wrap8_data beat %0d: got %h want %h", j, r_dat, ev);
            end
            tick();
        end
        vectors++;
        if (r_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap8_end: got ack=%b on 9th cycle want 0", r_ack);
        end
        m_cyc = 1'b0; m_stb = 1'b0; m_cti = 3'b000; m_bte = 2'b00;
        tick();
    endtask

    task automatic test_burst_drop();
        int lat;
        logic [31:0] rd, ev;
        logic as, es, aa, ea;
        use_b = 1'b0;
        for (int i = 0; i < 4; i++)
            wr(32'(4*i), 32'h5500_0000 + 32'(i), 4'hF);
        m_adr = 32'h0; m_we = 1'b1; m_dat = 32'hB000_0000; m_sel = 4'hF;
        m_cti = 3'b010; m_bte = 2'b00; m_cyc = 1'b1; m_stb = 1'b1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (r_ack) begin
                lat = i;
                break;
            end
        end
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("FAIL bd_first_lat: got %0d want 3", lat);
        end
        tick();
        model_write(32'h0, 32'hB000_0000, 4'hF);
        m_dat = 32'hB000_0001;
        vectors++;
        if (r_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL bd_beat1_ack: got %b want 1", r_ack);
        end
        tick();
        model_write(32'h4, 32'hB000_0001, 4'hF);
        m_dat = 32'hB000_0002;
        m_stb = 1'b0;
        tick();
        vectors++;
        if (r_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL bd_ack_drop: got %b want 0", r_ack);
        end
        m_cyc = 1'b0; m_we = 1'b0; m_cti = 3'b000;
        tick();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(model_read(32'(4*i)));
            classic(32'(4*i), 1'b0, 32'h0, 4'hF, lat, rd, as, es, aa, ea);
            vectors++;
            if (lat !== 3) begin
                miscompares++;
                $display("FAIL bd_restart_lat w%0d: got %0d want 3", i, lat);
            end
            ev = exp_q.pop_front();
            vectors++;
            if (rd !== ev) begin
                miscompares++;
                $display("FAIL bd_word w%0d: got %h want %h", i, rd, ev);
            end
        end
    endtask

    task automatic test_err();
        int lat;
        logic [31:0] rd, ev;
        logic as, es, aa, ea;
        use_b = 1'b1;
        classic(32'h2000_0000, 1'b1, 32'hBAD0BAD0, 4'hF, lat, rd, as, es, aa, ea);
        vectors++;
        if (es !== 1'b1 || lat !== 1) begin
            miscompares++;
            $display("FAIL err_raise: got err=%b lat=%0d want 1 1", es, lat);
        end
        vectors++;
        if (as !== 1'b0) begin
            miscompares++;
            $display("FAIL err_no_ack: got ack=%b want 0", as);
        end
        vectors++;
        if (ea !== 1'b0 || aa !== 1'b0) begin
            miscompares++;
            $display("FAIL err_one_cycle: got err=%b ack=%b want 0 0", ea, aa);
        end
        exp_q.push_back(model_read(32'h1000_0000));
        classic(32'h1000_0000, 1'b0, 32'h0, 4'hF, lat, rd, as, es, aa, ea);
        ev = exp_q.pop_front();
        vectors++;
        if (rd !== ev || lat !== 1) begin
            miscompares++;
            $display("FAIL err_mem_kept: got %h lat=%0d want %h 1", rd, lat, ev);
        end
    endtask

    task automatic test_reset_mid_burst();
        int lat;
        logic [31:0] rd, ev;
        logic as, es, aa, ea;
        use_b = 1'b1;
        exp_q.push_back(mb[1]);
        m_adr = 32'h1000_0004; m_we = 1'b0; m_sel = 4'hF;
        m_cti = 3'b010; m_bte = 2'b00; m_cyc = 1'b1; m_stb = 1'b1;
        tick();
        ev = exp_q.pop_front();
        vectors++;
        if (r_ack !== 1'b1 || r_dat !== ev) begin
            miscompares++;
            $display("FAIL rmb_beat0: got ack=%b dat=%h want 1 %h", r_ack, r_dat, ev);
        end
        tick();
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if (r_ack !== 1'b0 || r_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rmb_async_flags: got ack=%b err=%b want 0 0", r_ack, r_err);
        end
        vectors++;
        if (r_dat !== 32'h0) begin
            miscompares++;
            $display("FAIL rmb_async_dat: got %h want 00000000", r_dat);
        end
        m_cyc = 1'b0; m_stb = 1'b0; m_cti = 3'b000;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick(); tick();
        vectors++;
        if (r_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL rmb_idle: got ack=%b want 0", r_ack);
        end
        for (int i = 1; i < 3; i++) begin
            exp_q.push_back(mb[i]);
            classic(32'h1000_0000 + 32'(4*i), 1'b0, 32'h0, 4'hF,
                    lat, rd, as, es, aa, ea);
            ev = exp_q.pop_front();
            vectors++;
            if (rd !== ev || lat !== 1) begin
                miscompares++;
                $display("FAIL rmb_ram_kept w%0d: got %h lat=%0d want %h 1", i, rd, lat, ev);
            end
        end
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL sb_drain: got %0d left want 0", exp_q.size());
        end
    endtask

    initial begin
        m_adr = '0; m_dat = '0; m_sel = 4'h0; m_we = 1'b0;
        m_cyc = 1'b0; m_stb = 1'b0; m_cti = 3'b000; m_bte = 2'b00;
        use_b = 1'b0;
        test_reset();
        test_classic();
        test_wrap8();
        test_burst_drop();
        test_err();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
